ram_io_responder: RTL and testbench
===================================

# ram_io_responder

Memory-side responder for the CPU's byte-wide memory port. It returns read bytes one cycle after the address, commits writes on the clock edge, and decodes an I/O window at 0x30000 that feeds a transmit FIFO and drains a receive stream. It drives `cannot_read` back to the memory controller as transmit-FIFO backpressure, and sits between the CPU top-level and the board/host link.

## Interface
- ADDR_WIDTH, 17: RAM index width; RAM holds 2^ADDR_WIDTH bytes.
- TX_DEPTH_LOG2, 3: transmit FIFO depth = 2^TX_DEPTH_LOG2 entries.
- TX_MARGIN, 2: `cannot_read` asserts when free TX entries ≤ TX_MARGIN.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when low, no state changes.
- mem_a  in  32  byte address from the memory controller.
- mem_write  in  8  write data byte.
- is_write  in  1  1 = write `mem_write` to `mem_a`; 0 = read.
- mem_result  out  8  read data, registered.
- cannot_read  out  1  registered backpressure to the memory controller.
- tx_data  out  8  head byte of the TX FIFO.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  sink accepts `tx_data` this cycle.
- rx_data  in  8  incoming host byte.
- rx_valid  in  1  `rx_data` present.
- rx_ready  out  1  combinational pop strobe to the RX source.
- sim_end  out  1  sticky; set by a write to 0x30004.
- tx_overflow  out  1  sticky; set when a push finds the TX FIFO full.

## Operation
- Decode: `mem_a[17:16]==2'b11` selects I/O; otherwise RAM at index `mem_a[ADDR_WIDTH-1:0]`.
- RAM is a synchronous byte array and is not reset.
  - Write: stores on the edge.
  - Read: `mem_result <= ram[idx]`.
- I/O register map (bits [2:0] decoded, other low bits ignored):
  - Write 0x30000: push `mem_write` to the TX FIFO.
  - Read 0x30000: `mem_result <= rx_data` when `rx_valid`, else 0x00. `rx_ready` = 1 for exactly that cycle when `rx_valid`.
  - Read 0x30004: `mem_result <= {6'b0, rx_valid, tx_full}`.
  - Write 0x30004: sets `sim_end`.
  - Other I/O offsets: reads return 0x00; writes are ignored.
- TX FIFO: circular buffer with read/write pointers of width TX_DEPTH_LOG2+1 (the MSB distinguishes full from empty).
  - `tx_valid` = not empty; `tx_data` = head entry.
  - Pop on `tx_valid && tx_ready`.
  - Push while full: byte dropped, `tx_overflow` set. Exception: a pop in the same cycle frees a slot, so the push is accepted.
  - Simultaneous push and pop: count unchanged, both pointers advance.
- `cannot_read <= (DEPTH - next_count) <= TX_MARGIN`, computed from the post-update count.
- The memory controller is required to hold its request while `cannot_read`=1. The responder still services any request presented during that time (no drop beyond the overflow rule).
- `rdy`=0 freezes RAM, FIFO, `mem_result`, and the sticky flags; `rx_ready`=0.

## Timing
- Read latency is 1 cycle: the address presented in cycle N yields `mem_result` valid during cycle N+1. This matches a controller that samples `mem_result` one step after each byte address.
- A write in cycle N is visible to a read of the same byte issued in cycle N+1.
- A TX push in cycle N makes `tx_valid`=1 in cycle N+1 (when the FIFO was empty).
- `cannot_read` is updated in the same cycle as the count change, i.e. it is valid 1 cycle after the push or pop.
- Reset (`rst_n`=0, asynchronous): `mem_result`=0, `cannot_read`=0, `tx_valid`=0, `tx_data`=don't-care, `sim_end`=0, `tx_overflow`=0, FIFO pointers=0. RAM contents are retained.
- Reset asserted mid-burst: the FIFO empties immediately and any pending read result is lost.

## Test plan
- Write 0xA5 to address 0x00010, then read 0x00010 next cycle -> `mem_result`=0xA5 one cycle after the read address.
- Four-byte burst writes 0x11,0x22,0x33,0x44 to 0x100..0x103, then reads them back -> bytes returned in order, each with 1-cycle latency.
- `tx_ready`=0, push 6 bytes to 0x30000 (depth 8, margin 2) -> `cannot_read`=1 after the 6th push. 3 more pushes -> the 9th is dropped and `tx_overflow`=1. Raise `tx_ready` -> the first 8 bytes drain in order.
- FIFO full, push and pop in the same cycle -> byte accepted, count stays 8, `tx_overflow` stays 0.
- `rx_valid`=1 with `rx_data`=0x5C, read 0x30000 -> `mem_result`=0x5C, `rx_ready` pulsed for 1 cycle. Read 0x30004 with TX empty and no RX -> 0x00.
- Write to 0x30004 -> `sim_end`=1 next cycle. Drop `rst_n` mid-drain -> all outputs reset immediately and RAM byte 0x00010 still reads 0xA5.

Source files
------------

// File: rtl/ram_io_responder.sv
// Byte-wide memory responder: synchronous RAM plus an I/O window at 0x30000
// holding a TX FIFO with backpressure, an RX pop port and a sticky sim_end flag.
module ram_io_responder #(
    parameter int ADDR_WIDTH    = 17,
    parameter int TX_DEPTH_LOG2 = 3,
    parameter int TX_MARGIN     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_write,
    input  logic        is_write,
    output logic [7:0]  mem_result,
    output logic        cannot_read,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        sim_end,
    output logic        tx_overflow
);

    localparam int DEPTH = 1 << TX_DEPTH_LOG2;
    localparam int PW    = TX_DEPTH_LOG2 + 1;

    logic [7:0]            r_ram [0:(1 << ADDR_WIDTH)-1];
    logic [7:0]            r_tx_mem [0:DEPTH-1];
    logic [PW-1:0]         r_wptr, r_rptr;

    logic                  w_io;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [2:0]            w_off;
    logic                  w_ram_wr, w_tx_push, w_sim_wr, w_rd;
    logic                  w_empty, w_full, w_pop, w_push_ok;
    logic [PW-1:0]         w_wptr_nxt, w_rptr_nxt, w_next_count;
    logic                  w_cannot_read_nxt;
    logic [7:0]            w_rd_data;
    logic                  w_unused_hi;

    assign w_io        = (mem_a[17:16] == 2'b11);
    assign w_idx       = mem_a[ADDR_WIDTH-1:0];
    assign w_off       = mem_a[2:0];
    assign w_unused_hi = ^mem_a[31:18];

    assign w_ram_wr  = rdy && is_write && !w_io;
    assign w_tx_push = rdy && is_write && w_io && (w_off == 3'd0);
    assign w_sim_wr  = rdy && is_write && w_io && (w_off == 3'd4);
    assign w_rd      = rdy && !is_write;

    // Pointers carry one extra MSB: equal means empty, MSB-only difference means full.
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = ((r_wptr ^ r_rptr) == {1'b1, {TX_DEPTH_LOG2{1'b0}}});
    assign w_pop     = rdy && !w_empty && tx_ready;
    assign w_push_ok = w_tx_push && (!w_full || w_pop);

    assign w_wptr_nxt        = r_wptr + PW'(w_push_ok);
    assign w_rptr_nxt        = r_rptr + PW'(w_pop);
    assign w_next_count      = w_wptr_nxt - w_rptr_nxt;
    assign w_cannot_read_nxt = (PW'(DEPTH) - w_next_count) <= PW'(TX_MARGIN);

    assign tx_valid = !w_empty;
    assign tx_data  = r_tx_mem[r_rptr[TX_DEPTH_LOG2-1:0]];
    assign rx_ready = w_rd && w_io && (w_off == 3'd0) && rx_valid;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        w_rd_data = 8'h00;
        if (!w_io) begin
            w_rd_data = r_ram[w_idx];
        end else begin
            case (w_off)
                3'd0:    w_rd_data = rx_valid ? rx_data : 8'h00;
                3'd4:    w_rd_data = {6'b0, rx_valid, w_full};
                default: w_rd_data = 8'h00;
            endcase
        end
    end

    // NOTE: storage arrays have no reset; contents survive rst_n and only control state clears.
    always_ff @(posedge clk) begin
        if (w_ram_wr) begin
            r_ram[w_idx] <= mem_write;
        end
        if (w_push_ok) begin
            r_tx_mem[r_wptr[TX_DEPTH_LOG2-1:0]] <= mem_write;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            mem_result  <= 8'h00;
            cannot_read <= 1'b0;
            sim_end     <= 1'b0;
            tx_overflow <= 1'b0;
        end else if (rdy) begin
            r_wptr      <= w_wptr_nxt;
            r_rptr      <= w_rptr_nxt;
            cannot_read <= w_cannot_read_nxt;
            if (w_rd) begin
                mem_result <= w_rd_data;
            end
            if (w_sim_wr) begin
                sim_end <= 1'b1;
            end
            if (w_tx_push && !w_push_ok) begin
                tx_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_io_responder.sv
// Self-checking bench for ram_io_responder: directed scenarios followed by
// randomized traffic, all compared against a queue/array reference model.
module tb_ram_io_responder;

    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b0;
    logic [31:0] mem_a = '0;
    logic [7:0]  mem_write = '0;
    logic        is_write = 1'b0;
    logic [7:0]  mem_result;
    logic        cannot_read;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        sim_end;
    logic        tx_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ram_m [int];
    logic [7:0] tx_q [$];
    logic [7:0] exp_res = 8'h00;
    bit         exp_known = 1'b1;
    bit         exp_cr = 1'b0, exp_sim = 1'b0, exp_ovf = 1'b0;

    ram_io_responder #(.ADDR_WIDTH(17), .TX_DEPTH_LOG2(3), .TX_MARGIN(MARGIN)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .mem_a(mem_a), .mem_write(mem_write),
        .is_write(is_write), .mem_result(mem_result), .cannot_read(cannot_read),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .sim_end(sim_end), .tx_overflow(tx_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        if (exp_known) check("mem_result", mem_result, exp_res);
        check("tx_valid", tx_valid, tx_q.size() > 0);
        if (tx_q.size() > 0) check("tx_data", tx_data, tx_q[0]);
        check("cannot_read", cannot_read, exp_cr);
        check("sim_end", sim_end, exp_sim);
        check("tx_overflow", tx_overflow, exp_ovf);
    endtask

    // One bus cycle: drive on the falling edge, predict, then check after the rising edge.
    task automatic cyc(input logic [31:0] a, input logic [7:0] wd, input logic wr,
                       input logic txr, input logic [7:0] rxd, input logic rxv, input logic rv);
        bit io, pop, push, full;
        logic [2:0] off;
        int idx;
        @(negedge clk);
        mem_a = a; mem_write = wd; is_write = wr; tx_ready = txr;
        rx_data = rxd; rx_valid = rxv; rdy = rv;
        #1;
        io  = (a[17:16] == 2'b11);
        off = a[2:0];
        idx = int'(a[16:0]);
        check("rx_ready", rx_ready, rv && io && !wr && off == 3'd0 && rxv);
        if (rv && !wr) begin
            exp_known = 1'b1;
            if (!io) begin
                if (ram_m.exists(idx)) exp_res = ram_m[idx];
                else exp_known = 1'b0;
            end else if (off == 3'd0) exp_res = rxv ? rxd : 8'h00;
            else if (off == 3'd4) exp_res = {6'b0, rxv, tx_q.size() == DEPTH};
            else exp_res = 8'h00;
        end
        if (rv && wr && !io) ram_m[idx] = wd;
        if (rv && wr && io && off == 3'd4) exp_sim = 1'b1;
        full = (tx_q.size() == DEPTH);
        pop  = rv && txr && (tx_q.size() > 0);
        push = rv && wr && io && off == 3'd0;
        if (pop) void'(tx_q.pop_front());
        if (push) begin
            if (!full || pop) tx_q.push_back(wd);
            else exp_ovf = 1'b1;
        end
        if (rv) exp_cr = (DEPTH - tx_q.size()) <= MARGIN;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic rd(input logic [31:0] a, input logic txr);
        cyc(a, 8'h00, 1'b0, txr, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d, input logic txr);
        cyc(a, d, 1'b1, txr, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic model_reset();
        tx_q.delete();
        exp_res = 8'h00; exp_known = 1'b1;
        exp_cr = 1'b0; exp_sim = 1'b0; exp_ovf = 1'b0;
    endtask

    initial begin
        logic [31:0] a, hi;
        model_reset();
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        wr(32'h10, 8'hA5, 1'b0);
        rd(32'h10, 1'b0);
        check("read_a5", mem_result, 8'hA5);

        for (int i = 0; i < 4; i++) wr(32'h100 + i, 8'h11 * (i + 1), 1'b0);
        for (int i = 0; i < 4; i++) rd(32'h100 + i, 1'b0);

        cyc(32'h30000, 8'h00, 1'b0, 1'b0, 8'h5C, 1'b1, 1'b1);
        check("rx_read", mem_result, 8'h5C);
        rd(32'h30004, 1'b0);
        check("status_idle", mem_result, 8'h00);

        // Fill to full, then push and pop together: accepted, no overflow.
        for (int i = 0; i < DEPTH; i++) wr(32'h30000, 8'hB0 + i, 1'b0);
        rd(32'h30004, 1'b0);
        check("status_full", mem_result, 8'h01);
        wr(32'h30000, 8'hC8, 1'b1);
        check("full_pushpop_ovf", tx_overflow, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) rd(32'h30001, 1'b1);

        for (int i = 0; i < 9; i++) begin
            wr(32'h30000, 8'h40 + i, 1'b0);
            if (i == 4) check("cr_after5", cannot_read, 1'b0);
            if (i == 5) check("cr_after6", cannot_read, 1'b1);
        end
        check("overflow_9th", tx_overflow, 1'b1);
        for (int i = 0; i < 3; i++) rd(32'h30002, 1'b1);

        // rdy low freezes everything even with a write and pop request.
        cyc(32'h10, 8'hFF, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
        cyc(32'h30004, 8'h00, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0);

        wr(32'h30004, 8'h00, 1'b1);
        check("sim_end_set", sim_end, 1'b1);
        rd(32'h30003, 1'b1);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        rd(32'h10, 1'b0);
        check("ram_retained", mem_result, 8'hA5);

        for (int i = 0; i < 400; i++) begin
            hi = $urandom & 32'hFFFC_0000;
            if ($urandom_range(0, 9) < 5)
                a = hi | 32'h10 | 32'($urandom_range(0, 15)) | ($urandom & 32'h0001_0000);
            else
                a = hi | 32'h3_0000 | ($urandom & 32'h0000_FFF8) | 32'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) a[2:0] = 3'd4;
            cyc(a, 8'($urandom), 1'($urandom), $urandom_range(0, 9) < 3,
                8'($urandom), 1'($urandom), $urandom_range(0, 9) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
